// File: rtl/cfg_loader_pkg.sv
// Package: cfg_loader_pkg
//   Shared types and constants for the configuration chain loader.
//   state_e    : loader FSM states (VERIFY/ERR exist only when CFG_READBACK_EN is defined)
//   CRC16_POLY : CRC-16/CCITT polynomial used by the readback check
//   CRC16_INIT : CRC register seed
package cfg_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SHIFT,
`ifdef CFG_READBACK_EN
      ST_VERIFY,
      ST_ERR,
`endif
      ST_DONE
   } state_e;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/cfg_crc16.sv
// Module: cfg_crc16
//   Serial (1 bit per enabled cycle) CRC-16, MSB-first feedback.
//   clk  in  block clock
//   rst  in  asynchronous active-low reset (register returns to CRC16_INIT)
//   clr  in  synchronous reseed to CRC16_INIT (has priority over en)
//   en   in  fold din into the CRC this cycle
//   din  in  serial data bit
//   crc  out current CRC register
module cfg_crc16
   import cfg_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic [15:0] crc_q, crc_d;
   logic        fb;

   always_comb begin
      fb    = crc_q[15] ^ din;
      crc_d = crc_q;
      if (clr) begin
         crc_d = CRC16_INIT;
      end else if (en) begin
         crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) crc_q <= CRC16_INIT;
      else      crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// Module: cfg_chain_loader
//   Loads CHAIN_LEN bits from a valid/ready word stream into a serial
//   configuration chain using a divided, registered prog_clk.
//   Build option: define CFG_READBACK_EN to add a VERIFY pass that recirculates
//   the chain (prog_in = prog_out) and compares CRC-16 of sent vs returned bits.
//   Ports:
//     clk, rst (async active-low)      block clock / reset
//     start                            begin a load (IDLE/DONE/ERR only)
//     s_valid, s_data, s_ready         config word stream, bit 0 shifted first
//     prog_clk, prog_en, prog_in       chain drive
//     prog_out                         chain tail return
//     busy, done, error                status levels
module cfg_chain_loader
   import cfg_loader_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 1024,
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned DIV       = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   input  logic [WORD_W-1:0] s_data,
   output logic              s_ready,
   output logic              prog_clk,
   output logic              prog_en,
   output logic              prog_in,
   input  logic              prog_out,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int unsigned BCW = $clog2(CHAIN_LEN + 1);
   localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned WIW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BCW-1:0] BIT_LAST = BCW'(CHAIN_LEN);
   localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
   localparam logic [WIW-1:0] IDX_LAST = WIW'(WORD_W - 1);

   state_e            state_q, state_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [WIW-1:0]    bit_idx_q, bit_idx_d, bit_idx_inc;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d, bit_cnt_inc;
   logic [DCW-1:0]    div_cnt_q, div_cnt_d;
   logic              prog_clk_q, prog_clk_d;
   logic              prog_en_q, prog_en_d;
   logic              prog_in_q, prog_in_d;
   logic              s_ready_q, s_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              launch, shifting, fall;

`ifdef CFG_READBACK_EN
   logic        rise;
   logic [15:0] crc_tx, crc_rb;

   assign shifting = (state_q == ST_SHIFT) || (state_q == ST_VERIFY);
   assign launch   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
   assign rise     = shifting && !prog_clk_q && (div_cnt_q == DIV_LAST);

   // Sent bits are folded at each rise; returned bits are sampled on the
   // clk cycle before each verify rise.
   cfg_crc16 u_crc_tx (
      .clk (clk), .rst (rst), .clr (launch),
      .en  (rise && (state_q == ST_SHIFT)), .din (prog_in_q), .crc (crc_tx)
   );
   cfg_crc16 u_crc_rb (
      .clk (clk), .rst (rst), .clr (launch),
      .en  (rise && (state_q == ST_VERIFY)), .din (prog_out), .crc (crc_rb)
   );
`else
   logic unused_prog_out;

   assign unused_prog_out = prog_out;
   assign shifting        = (state_q == ST_SHIFT);
   assign launch          = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
`endif

   assign fall = shifting && prog_clk_q && (div_cnt_q == DIV_LAST);

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      bit_idx_d   = bit_idx_q;
      bit_cnt_d   = bit_cnt_q;
      div_cnt_d   = div_cnt_q;
      prog_clk_d  = prog_clk_q;
      prog_en_d   = prog_en_q;
      prog_in_d   = prog_in_q;
      s_ready_d   = s_ready_q;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;
      bit_cnt_inc = bit_cnt_q + 1'b1;
      bit_idx_inc = bit_idx_q + 1'b1;

      // Free-running divider while shifting; each bit is DIV low + DIV high.
      if (shifting) begin
         if (div_cnt_q == DIV_LAST) begin
            div_cnt_d  = '0;
            prog_clk_d = ~prog_clk_q;
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
      end

      if (launch) begin
         state_d    = ST_FETCH;
         s_ready_d  = 1'b1;
         prog_en_d  = 1'b1;
         busy_d     = 1'b1;
         done_d     = 1'b0;
         error_d    = 1'b0;
         bit_cnt_d  = '0;
         div_cnt_d  = '0;
         prog_clk_d = 1'b0;
      end

      unique case (state_q)
         ST_FETCH: begin
            // Divider is frozen here, so a starved stream holds prog_clk low.
            if (s_valid && s_ready_q) begin
               word_d    = s_data;
               prog_in_d = s_data[0];
               bit_idx_d = '0;
               s_ready_d = 1'b0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // Next bit is presented on the same edge prog_clk falls.
            if (fall) begin
               bit_cnt_d = bit_cnt_inc;
               if (bit_cnt_inc == BIT_LAST) begin
`ifdef CFG_READBACK_EN
                  state_d   = ST_VERIFY;
                  bit_cnt_d = '0;
                  prog_in_d = prog_out;
`else
                  state_d   = ST_DONE;
                  prog_en_d = 1'b0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
`endif
               end else if (bit_idx_q == IDX_LAST) begin
                  state_d   = ST_FETCH;
                  s_ready_d = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_inc;
                  prog_in_d = word_q[bit_idx_inc];
               end
            end
         end
`ifdef CFG_READBACK_EN
         ST_VERIFY: begin
            if (fall) begin
               bit_cnt_d = bit_cnt_inc;
               if (bit_cnt_inc == BIT_LAST) begin
                  prog_en_d = 1'b0;
                  busy_d    = 1'b0;
                  if (crc_tx == crc_rb) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_ERR;
                     error_d = 1'b1;
                  end
               end else begin
                  prog_in_d = prog_out;
               end
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         word_q     <= '0;
         bit_idx_q  <= '0;
         bit_cnt_q  <= '0;
         div_cnt_q  <= '0;
         prog_clk_q <= 1'b0;
         prog_en_q  <= 1'b0;
         prog_in_q  <= 1'b0;
         s_ready_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         bit_idx_q  <= bit_idx_d;
         bit_cnt_q  <= bit_cnt_d;
         div_cnt_q  <= div_cnt_d;
         prog_clk_q <= prog_clk_d;
         prog_en_q  <= prog_en_d;
         prog_in_q  <= prog_in_d;
         s_ready_q  <= s_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign s_ready  = s_ready_q;
   assign prog_clk = prog_clk_q;
   assign prog_en  = prog_en_q;
   assign prog_in  = prog_in_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader (CHAIN_LEN=20, WORD_W=8, DIV=2).
// The chain is modelled as a 20-bit shift register clocked by prog_clk while
// prog_en is high. A transaction-level model derives the expected prog_clk
// waveform, data bits and status levels from handshake times.
module tb_cfg_chain_loader;

   localparam int L   = 20;
   localparam int W   = 8;
   localparam int DIV = 2;
`ifdef CFG_READBACK_EN
   localparam int BASE = 2 * L * 2 * DIV;
`else
   localparam int BASE = L * 2 * DIV;
`endif

   logic         clk = 1'b0;
   logic         rst, start, s_valid;
   logic [W-1:0] s_data;
   logic         s_ready, prog_clk, prog_en, prog_in, prog_out, busy, done, error;

   cfg_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .DIV(DIV)) dut (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .prog_clk(prog_clk), .prog_en(prog_en), .prog_in(prog_in),
      .prog_out(prog_out), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int t_start = 0;
   bit inject = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Chain model: head shifts in at the top, first bit sent ends at chain[0].
   logic [L-1:0] chain = '0;
   int           rise_cnt = 0;

   always @(posedge prog_clk or negedge prog_en) begin
      if (!prog_en) begin
         rise_cnt = 0;
      end else begin
         chain = {prog_in, chain[L-1:1]};
         rise_cnt++;
         if (inject && rise_cnt == L) chain[7] = ~chain[7];
      end
   end
   assign prog_out = chain[0];

   // Transaction-level expectation model, advanced and checked each negedge.
   bit           m_active, m_done, m_err, m_fetch, m_inword, m_verify;
   bit           pend_start, pend_acc;
   logic [W-1:0] pend_data, m_word;
   logic [L-1:0] sent;
   int           m_k, m_nb, m_bits;

   function automatic logic exp_bit(input int j);
      if (m_verify) return sent[j] ^ (inject && j == 7);
      return m_word[j];
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         {m_active, m_done, m_err, m_fetch, m_inword, m_verify} = '0;
         {pend_start, pend_acc} = '0;
         chk("rst_outputs", {s_ready, prog_clk, prog_en, busy, done, error}, 6'b0);
      end else begin
         if (pend_start) begin
            {m_active, m_fetch} = 2'b11;
            {m_done, m_err, m_inword, m_verify} = '0;
            m_bits = 0;
         end else if (pend_acc) begin
            m_fetch  = 1'b0;
            m_inword = 1'b1;
            m_k      = 0;
            m_word   = pend_data;
            m_nb     = (L - m_bits < W) ? L - m_bits : W;
            for (int j = 0; j < m_nb; j++) sent[m_bits + j] = pend_data[j];
         end else if (m_inword) begin
            m_k++;
            if (m_k == m_nb * 2 * DIV) begin
               m_inword = 1'b0;
               if (m_verify) begin
                  m_verify = 1'b0;
                  m_active = 1'b0;
                  m_done   = !inject;
                  m_err    = inject;
               end else begin
                  m_bits += m_nb;
                  if (m_bits == L) begin
`ifdef CFG_READBACK_EN
                     m_verify = 1'b1;
                     m_inword = 1'b1;
                     m_k      = 0;
                     m_nb     = L;
`else
                     m_active = 1'b0;
                     m_done   = 1'b1;
`endif
                  end else begin
                     m_fetch = 1'b1;
                  end
               end
            end
         end
         chk("prog_en", prog_en, m_active);
         chk("busy", busy, m_active);
         chk("s_ready", s_ready, m_fetch);
         chk("done", done, m_done);
         chk("error", error, m_err);
         chk("prog_clk", prog_clk, m_inword && ((m_k % (2 * DIV)) >= DIV));
         if (m_inword) chk("prog_in", prog_in, exp_bit(m_k / (2 * DIV)));
         pend_start = start && !m_active;
         pend_acc   = s_valid && m_fetch;
         pend_data  = s_data;
      end
   end

   // Present one word (after an optional stall) and hold it until taken.
   task automatic feed(input logic [W-1:0] w, input int stall);
      bit taken = 1'b0;
      if (stall > 0) begin
         repeat (stall) @(posedge clk);
         #1;
         chk("stall_prog_clk", prog_clk, 1'b0);
         chk("stall_prog_en", prog_en, 1'b1);
      end
      s_valid = 1'b1;
      s_data  = w;
      for (int n = 0; n < 200 && !taken; n++) begin
         @(negedge clk);
         if (s_ready) taken = 1'b1;
      end
      if (!taken) chk("handshake_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic do_load(input logic [W-1:0] w0, w1, w2, input int stall1,
                          input bit early, input bit mid_start);
      if (early) begin
         s_valid = 1'b1;
         s_data  = w0;
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      t_start = cyc;
      feed(w0, 0);
      if (mid_start) begin
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      feed(w1, stall1);
      feed(w2, 0);
   endtask

   task automatic wait_end(input string nm, input bit stall_run);
      bit fin = 1'b0;
      int lat;
      for (int n = 0; n < 1000 && !fin; n++) begin
         @(negedge clk);
         if (done || error) fin = 1'b1;
      end
      lat = cyc - t_start;
      n_cmp++;
      if (!fin || (!stall_run && (lat < BASE || lat > BASE + 7))) begin
         n_bad++;
         $display("FAIL %s_cycles: got %0d expected %0d..%0d (finished=%0d)", nm, lat, BASE, BASE + 7, fin);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
      #12;
      chk("reset_state", {s_ready, prog_clk, prog_en, prog_in, busy, done, error}, 7'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Back-to-back words; high nibble of 0x0F is beyond the chain.
      do_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 1'b0);
      wait_end("load1", 1'b0);
      chk("load1_chain", chain, 20'hF3CA5);
      chk("load1_status", {busy, done, error}, 3'b010);

      // 50-cycle starvation before word 2.
      do_load(8'hA5, 8'h3C, 8'h0F, 50, 1'b0, 1'b0);
      wait_end("load2", 1'b1);
      chk("load2_chain", chain, 20'hF3CA5);
      chk("load2_done", done, 1'b1);

      // Asynchronous reset while prog_clk is high mid-word.
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      feed(8'h00, 0);
      for (int n = 0; n < 20 && !prog_clk; n++) @(negedge clk);
      #3 rst = 1'b0;
      #1;
      chk("async_rst_drop", {prog_en, prog_clk, busy, s_ready, done}, 5'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      do_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 1'b0);
      wait_end("load3", 1'b0);
      chk("load3_chain", chain, 20'hF3CA5);

      // Word offered with start; start pulsed mid-load; high nibble of 0xF0 ignored.
      do_load(8'h5A, 8'hC3, 8'hF0, 0, 1'b1, 1'b1);
      wait_end("load4", 1'b0);
      chk("load4_chain", chain, 20'h0C35A);
      chk("load4_status", {busy, done, error}, 3'b010);

`ifdef CFG_READBACK_EN
      // Readback with a corrupted bit 7.
      inject = 1'b1;
      do_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 1'b0);
      wait_end("load5", 1'b0);
      chk("verify_err_status", {busy, done, error}, 3'b001);
      chk("verify_err_chain", chain, 20'hF3C25);
      inject = 1'b0;
      do_load(8'hA5, 8'h3C, 8'h0F, 0, 1'b0, 1'b0);
      wait_end("load6", 1'b0);
      chk("verify_ok_status", {busy, done, error}, 3'b010);
      chk("verify_ok_chain", chain, 20'hF3CA5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
